// File: rtl/scan_scheduler.sv
// scan_scheduler: steps (img_index, row_index, col_index) over every window of every pyramid level.
// Defining SCAN_PERF_CNT_EN adds the stall_cycles / win_count performance counters.

`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 2
`endif
`ifndef WINDOW_SIZE
`define WINDOW_SIZE 24
`endif
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd26, 32'd30}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd25, 32'd28}
`endif

module scan_scheduler #(
    parameter int unsigned                      PYRAMID_LEVELS  = `PYRAMID_LEVELS,
    parameter int unsigned                      WINDOW_SIZE     = `WINDOW_SIZE,
    parameter logic [PYRAMID_LEVELS-1:0][31:0]  LEVEL_WIDTHS    = `PYRAMID_WIDTHS,
    parameter logic [PYRAMID_LEVELS-1:0][31:0]  LEVEL_HEIGHTS   = `PYRAMID_HEIGHTS,
    parameter int unsigned                      INT_WAIT_CYCLES = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        img_rdy,
    input  logic        win_ready,
    output logic        win_valid,
    output logic [3:0]  img_index,
    output logic [31:0] row_index,
    output logic [31:0] col_index,
    output logic        level_last,
    output logic        frame_last,
    output logic        busy,
    output logic        frame_done,
    output logic        start_dropped
`ifdef SCAN_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] win_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0]  IDLE_INDEX = 4'd15;
    localparam logic [3:0]  LAST_LEVEL = 4'(PYRAMID_LEVELS - 1);
    localparam logic [31:0] WAIT_LIMIT = 32'(INT_WAIT_CYCLES);
    localparam logic [31:0] WIN_EDGE   = 32'(WINDOW_SIZE);

    state_t      state_r;
    logic [31:0] wait_cnt_r;
    logic [31:0] cur_w_s;
    logic [31:0] cur_h_s;
    logic        col_end_s;
    logic        row_end_s;
    logic        lvl_end_s;

    // Every level must leave room for at least one window in each direction.
    if (PYRAMID_LEVELS < 1 || PYRAMID_LEVELS > 15) begin : g_bad_levels
        $error("scan_scheduler: PYRAMID_LEVELS must be 1..15");
    end
    for (genvar g = 0; g < PYRAMID_LEVELS; g++) begin : g_dim_check
        if (LEVEL_WIDTHS[g] <= WIN_EDGE || LEVEL_HEIGHTS[g] <= WIN_EDGE) begin : g_bad_level
            $error("scan_scheduler: pyramid level %0d is not larger than the scan window", g);
        end
    end

    // Look up the dimensions of the level currently being scanned.
    always_comb begin
        cur_w_s = LEVEL_WIDTHS[0];
        cur_h_s = LEVEL_HEIGHTS[0];
        for (int unsigned i = 0; i < PYRAMID_LEVELS; i++) begin
            cur_w_s = (img_index == 4'(i)) ? LEVEL_WIDTHS[i]  : cur_w_s;
            cur_h_s = (img_index == 4'(i)) ? LEVEL_HEIGHTS[i] : cur_h_s;
        end
    end

    assign col_end_s  = (col_index >= (cur_w_s - WIN_EDGE - 32'd1));
    assign row_end_s  = (row_index >= (cur_h_s - WIN_EDGE - 32'd1));
    assign lvl_end_s  = (img_index >= LAST_LEVEL);
    assign level_last = win_valid & col_end_s & row_end_s;
    assign frame_last = level_last & lvl_end_s;

    // Frame sequencer: settle wait, raster stepping per level, one-cycle end-of-frame pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= 32'd0;
            win_valid     <= 1'b0;
            img_index     <= IDLE_INDEX;
            row_index     <= 32'd0;
            col_index     <= 32'd0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            start_dropped <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            start_dropped <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (img_rdy) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= 32'd1;
                        busy       <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A newer image supersedes the pending one, so the settle time restarts.
                    if (img_rdy) begin
                        wait_cnt_r <= 32'd1;
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        state_r   <= ST_SCAN;
                        win_valid <= 1'b1;
                        img_index <= 4'd0;
                        row_index <= 32'd0;
                        col_index <= 32'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_SCAN: begin
                    start_dropped <= img_rdy;
                    if (win_ready) begin
                        if (!col_end_s) begin
                            col_index <= col_index + 32'd1;
                        end else if (!row_end_s) begin
                            col_index <= 32'd0;
                            row_index <= row_index + 32'd1;
                        end else if (!lvl_end_s) begin
                            img_index <= img_index + 4'd1;
                            row_index <= 32'd0;
                            col_index <= 32'd0;
                        end else begin
                            state_r    <= ST_DONE;
                            win_valid  <= 1'b0;
                            img_index  <= IDLE_INDEX;
                            row_index  <= 32'd0;
                            col_index  <= 32'd0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    start_dropped <= img_rdy;
                    state_r       <= ST_IDLE;
                    busy          <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    win_valid <= 1'b0;
                    img_index <= IDLE_INDEX;
                    row_index <= 32'd0;
                    col_index <= 32'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_PERF_CNT_EN
    // Stall and handshake counters, restarted whenever an image enters the settle wait.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 32'd0;
            win_count    <= 32'd0;
        end else if (img_rdy && (state_r == ST_IDLE || state_r == ST_WAIT)) begin
            stall_cycles <= 32'd0;
            win_count    <= 32'd0;
        end else if (state_r == ST_SCAN) begin
            if (win_ready) begin
                win_count <= win_count + 32'd1;
            end else begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_scheduler.sv
// Randomised self-checking bench for scan_scheduler: a window-list model predicts every output each cycle.
module tb_scan_scheduler;

    localparam int IWAIT = 10;
    localparam int WS    = 24;
    localparam logic [1:0][31:0] WIDTHS  = {32'd26, 32'd30};
    localparam logic [1:0][31:0] HEIGHTS = {32'd25, 32'd28};

    int lw [2] = '{30, 26};
    int lh [2] = '{28, 25};

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        img_rdy   = 1'b0;
    logic        win_ready = 1'b0;
    logic        win_valid;
    logic [3:0]  img_index;
    logic [31:0] row_index;
    logic [31:0] col_index;
    logic        level_last;
    logic        frame_last;
    logic        busy;
    logic        frame_done;
    logic        start_dropped;
`ifdef SCAN_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] win_count;
`endif

    always #5 clock = ~clock;

    scan_scheduler #(
        .PYRAMID_LEVELS  (2),
        .WINDOW_SIZE     (WS),
        .LEVEL_WIDTHS    (WIDTHS),
        .LEVEL_HEIGHTS   (HEIGHTS),
        .INT_WAIT_CYCLES (IWAIT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .img_rdy       (img_rdy),
        .win_ready     (win_ready),
        .win_valid     (win_valid),
        .img_index     (img_index),
        .row_index     (row_index),
        .col_index     (col_index),
        .level_last    (level_last),
        .frame_last    (frame_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .start_dropped (start_dropped)
`ifdef SCAN_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .win_count     (win_count)
`endif
    );

    // Ordered list of every window the frame must present.
    int exp_lvl[$];
    int exp_row[$];
    int exp_col[$];
    int n_win = 0;

    // Model state: frame pending/scanning, cycle of first window, index into the list.
    int cyc = 0;
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    bit m_drop = 1'b0;
    int m_first = 0;
    int m_k = 0;
    int m_stall = 0;
    int m_wcnt = 0;

    // Written by the stimulus only.
    int start_cyc = 0;
    int exp_first_lat = -1;
    int exp_done_lat = -1;
    int exp_drops = -1;
    int exp_stall = -1;
    int tmo_req = 0;

    // Written by the compare process only.
    int n_chk = 0;
    int n_err = 0;
    int done_total = 0;
    int tmo_seen = 0;
    int first_rise = -1;
    int hs_frame = 0;
    int drop_frame = 0;
    int fl_n = 0;
    int ll_q[$];
    int e_valid, e_img, e_row, e_col, e_ll, e_fl, e_busy, e_done, e_drop, e_st, e_wc;
    bit e_scan;

    // Model update on each clock edge from the inputs of the cycle that just ended.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_drop   <= 1'b0;
            m_k      <= 0;
            m_stall  <= 0;
            m_wcnt   <= 0;
        end else begin
            m_done <= 1'b0;
            m_drop <= 1'b0;
            if (m_active && cyc >= m_first) begin
                m_drop <= img_rdy;
                if (win_ready) begin
                    m_wcnt <= m_wcnt + 1;
                    if (m_k == n_win - 1) begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end else begin
                    m_stall <= m_stall + 1;
                end
            end else if (m_done) begin
                m_drop <= img_rdy;
            end else if (img_rdy) begin
                m_active <= 1'b1;
                m_first  <= cyc + IWAIT + 1;
                m_k      <= 0;
                m_stall  <= 0;
                m_wcnt   <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle against the model, plus per-frame literal expectations.
    always @(negedge clock) begin
        if (cyc > 0) begin
            if (!reset_n) begin
                e_valid = 0; e_img = 15; e_row = 0; e_col = 0; e_ll = 0; e_fl = 0;
                e_busy = 0; e_done = 0; e_drop = 0; e_st = 0; e_wc = 0;
            end else begin
                e_scan  = m_active && (cyc >= m_first);
                e_valid = e_scan ? 1 : 0;
                e_img   = e_scan ? exp_lvl[m_k] : 15;
                e_row   = e_scan ? exp_row[m_k] : 0;
                e_col   = e_scan ? exp_col[m_k] : 0;
                e_fl    = (e_scan && m_k == n_win - 1) ? 1 : 0;
                e_ll    = (e_scan && (m_k == n_win - 1 || exp_lvl[m_k + 1] != exp_lvl[m_k])) ? 1 : 0;
                e_busy  = (m_active || m_done) ? 1 : 0;
                e_done  = m_done ? 1 : 0;
                e_drop  = m_drop ? 1 : 0;
                e_st    = m_stall;
                e_wc    = m_wcnt;
            end
            chk("win_valid", int'(win_valid), e_valid);
            chk("img_index", int'(img_index), e_img);
            chk("row_index", int'(row_index), e_row);
            chk("col_index", int'(col_index), e_col);
            chk("level_last", int'(level_last), e_ll);
            chk("frame_last", int'(frame_last), e_fl);
            chk("busy", int'(busy), e_busy);
            chk("frame_done", int'(frame_done), e_done);
            chk("start_dropped", int'(start_dropped), e_drop);
`ifdef SCAN_PERF_CNT_EN
            chk("stall_cycles", int'(stall_cycles), e_st);
            chk("win_count", int'(win_count), e_wc);
`endif
        end
        if (!reset_n) begin
            first_rise = -1; hs_frame = 0; drop_frame = 0; fl_n = 0; ll_q.delete();
        end else begin
            if (img_rdy && !busy) begin
                first_rise = -1; hs_frame = 0; drop_frame = 0; fl_n = 0; ll_q.delete();
            end
            if (win_valid && first_rise < 0) first_rise = cyc;
            if (win_valid && win_ready) begin
                hs_frame++;
                if (level_last) ll_q.push_back(int'(img_index) * 10000 + int'(row_index) * 100 + int'(col_index));
                if (frame_last) fl_n++;
            end
            if (start_dropped) drop_frame++;
            if (frame_done) begin
                done_total++;
                if (exp_first_lat >= 0) chk("first_valid_cycle", first_rise - start_cyc, exp_first_lat);
                if (exp_done_lat >= 0) chk("frame_done_cycle", cyc - start_cyc, exp_done_lat);
                if (exp_drops >= 0) chk("start_dropped_pulses", drop_frame, exp_drops);
                chk("handshakes", hs_frame, 26);
                chk("level_last_count", ll_q.size(), 2);
                if (ll_q.size() == 2) begin
                    chk("level0_last_pos", ll_q[0], 305);
                    chk("level1_last_pos", ll_q[1], 10001);
                end
                chk("frame_last_count", fl_n, 1);
`ifdef SCAN_PERF_CNT_EN
                if (exp_stall >= 0) chk("stall_cycles_final", int'(stall_cycles), exp_stall);
                chk("win_count_final", int'(win_count), 26);
`endif
            end
        end
        if (tmo_req != tmo_seen) begin
            n_chk++;
            n_err++;
            $display("FAIL frame_timeout: frame_done count %0d, expected one more frame", done_total);
            tmo_seen = tmo_req;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: ready high, 1: ready toggles, 2: random ready and random img_rdy.
    task automatic run_frame(input int mode, input int restart_at, input int drop_at, input int abort_at);
        int base;
        int rel;
        bit fin;
        base = done_total;
        fin = 1'b0;
        start_cyc = cyc;
        win_ready = 1'b1;
        img_rdy = 1'b1;
        tick();
        img_rdy = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            rel = cyc - start_cyc;
            if (rel == abort_at) begin
                reset_n = 1'b0;
                img_rdy = 1'b0;
                repeat (3) tick();
                reset_n = 1'b1;
                tick();
                fin = 1'b1;
            end else if (done_total != base) begin
                fin = 1'b1;
            end else begin
                img_rdy = (rel == restart_at) || (rel == drop_at) ||
                          (mode == 2 && $urandom_range(0, 15) == 0);
                if (mode == 0) win_ready = 1'b1;
                else if (mode == 1) win_ready = (rel % 2 == 0);
                else win_ready = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        img_rdy = 1'b0;
        win_ready = 1'b1;
        if (!fin) tmo_req++;
    endtask

    initial begin
        for (int lv = 0; lv < 2; lv++)
            for (int r = 0; r < lh[lv] - WS; r++)
                for (int c = 0; c < lw[lv] - WS; c++) begin
                    exp_lvl.push_back(lv);
                    exp_row.push_back(r);
                    exp_col.push_back(c);
                end
        n_win = exp_lvl.size();

        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        exp_first_lat = 11; exp_done_lat = 37; exp_drops = 0; exp_stall = 0;
        run_frame(0, -1, -1, -1);
        repeat (4) tick();

        exp_done_lat = 63; exp_stall = 26;
        run_frame(1, -1, -1, -1);
        repeat (4) tick();

        exp_first_lat = 16; exp_done_lat = 42; exp_stall = 0;
        run_frame(0, 5, -1, -1);
        repeat (4) tick();

        exp_first_lat = 11; exp_done_lat = 37; exp_drops = 1;
        run_frame(0, -1, 21, -1);
        repeat (4) tick();

        exp_drops = 0;
        run_frame(0, -1, -1, 23);
        repeat (3) tick();
        run_frame(0, -1, -1, -1);
        repeat (4) tick();

        exp_first_lat = -1; exp_done_lat = -1; exp_drops = -1; exp_stall = -1;
        for (int f = 0; f < 4; f++) begin
            run_frame(2, -1, -1, -1);
            repeat ($urandom_range(2, 6)) tick();
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
